// File: rtl/count_uart_tx.sv
// count_uart_tx: serialises counter bytes onto a UART TX line (start, 8 data LSB first, optional even parity, stop)
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous reset, active-high
//   in_data   byte to transmit, sampled on accept
//   in_valid  in_data is valid
//   in_ready  block can accept a byte this cycle
//   tx        UART serial line, idle high, driven from a flop
//   busy      frame in progress
//   done      one-cycle pulse on the first idle cycle after a frame
module count_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter bit          PARITY_EN    = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       done
);
    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
        $error("count_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end
    localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    logic [2:0]    state;
    logic [BW-1:0] baud;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          par;
    assign in_ready = (state == IDLE) && !rst;
    assign busy     = state != IDLE;
    // tx is loaded with the next state's line level at every transition so
    // it changes only on bit boundaries and always comes straight from a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            baud  <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            tx    <= 1'b1;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (in_valid) begin
                    shift <= in_data;
                    par   <= ^in_data;
                    baud  <= '0;
                    state <= START;
                    tx    <= 1'b0;
                end
            end else if (baud != BAUD_LAST) begin
                baud <= baud + BW'(1);
            end else begin
                baud <= '0;
                case (state)
                    START: begin
                        state <= DATA;
                        idx   <= '0;
                        tx    <= shift[0];
                    end
                    DATA: begin
                        if (idx == 3'd7) begin
                            state <= PARITY_EN ? PARITY : STOP;
                            tx    <= PARITY_EN ? par : 1'b1;
                        end else begin
                            idx   <= idx + 3'd1;
                            shift <= {1'b0, shift[7:1]};
                            tx    <= shift[1];
                        end
                    end
                    PARITY: begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        done  <= 1'b1;
                    end
                endcase
            end
        end
    end
endmodule
